// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetches take strict priority and
// CPU reads/byte-writes fill the remaining slots through a stb/ack handshake.
module vram_arbiter #(
   parameter int AW     = 14,
   parameter int RD_LAT = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [15:0]   vid_data,
   output logic          vid_valid,
   input  logic          cpu_stb,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_din,
   input  logic [1:0]    cpu_wtbt,
   output logic [15:0]   cpu_dout,
   output logic          cpu_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [1:0]    ram_be,
   output logic [15:0]   ram_wdata,
   input  logic [15:0]   ram_rdata,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, CPU_WR} state_t;

   state_t        state, next_state;
   logic          vid_pend;
   logic [AW-1:0] pend_addr;
   logic          cpu_done;
   logic [2:0]    lat_cnt;
   logic          grant_vid, grant_cpu, rd_last, cpu_finish;

   // CPU handshake: cpu_stb is a level held until cpu_ack; cpu_ack stays
   // high until cpu_stb drops and falls on the following cycle.
   assign cpu_ack   = cpu_done;
   assign dbg_state = state;

   always_comb begin
      next_state = state;
      grant_vid  = 1'b0;
      grant_cpu  = 1'b0;
      rd_last    = 1'b0;
      cpu_finish = 1'b0;
      case (state)
         IDLE: begin
            if (vid_req || vid_pend) begin
               grant_vid  = 1'b1;
               next_state = VID_RD;
            end else if (cpu_stb && !cpu_done) begin
               grant_cpu  = 1'b1;
               next_state = cpu_we ? CPU_WR : CPU_RD;
            end
         end
         VID_RD: begin
            if (lat_cnt == 3'd0) begin
               rd_last    = 1'b1;
               next_state = IDLE;
            end
         end
         CPU_RD: begin
            if (lat_cnt == 3'd0) begin
               rd_last    = 1'b1;
               cpu_finish = 1'b1;
               next_state = IDLE;
            end
         end
         CPU_WR: begin
            cpu_finish = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= IDLE;
         vid_pend  <= 1'b0;
         pend_addr <= '0;
         cpu_done  <= 1'b0;
         lat_cnt   <= 3'd0;
         vid_valid <= 1'b0;
         vid_data  <= 16'h0000;
         cpu_dout  <= 16'h0000;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_be    <= 2'b11;
         ram_wdata <= 16'h0000;
      end else begin
         state     <= next_state;
         vid_valid <= 1'b0;
         ram_we    <= 1'b0;

         if ((state == VID_RD || state == CPU_RD) && lat_cnt != 3'd0)
            lat_cnt <= lat_cnt - 3'd1;

         // A request that is not granted this cycle is parked; a newer one
         // simply overwrites the parked address so only one fetch happens.
         if (grant_vid)
            vid_pend <= 1'b0;
         else if (vid_req) begin
            vid_pend  <= 1'b1;
            pend_addr <= vid_addr;
         end

         if (grant_vid) begin
            ram_addr <= vid_req ? vid_addr : pend_addr;
            ram_be   <= 2'b11;
            lat_cnt  <= 3'(RD_LAT);
         end else if (grant_cpu) begin
            ram_addr <= cpu_addr;
            ram_we   <= cpu_we;
            ram_be   <= (cpu_we && cpu_wtbt != 2'b00) ? cpu_wtbt : 2'b11;
            lat_cnt  <= 3'(RD_LAT);
            if (cpu_we)
               ram_wdata <= cpu_din;
         end

         if (rd_last) begin
            if (state == VID_RD) begin
               vid_data  <= ram_rdata;
               vid_valid <= 1'b1;
            end else
               cpu_dout <= ram_rdata;
         end

         // An aborted CPU access still completes at the RAM but never acks.
         if (!cpu_stb)
            cpu_done <= 1'b0;
         else if (cpu_finish)
            cpu_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, reference memory image and
// directed plus randomized arbitration scenarios.
module tb_vram_arbiter;
   localparam int AW      = 14;
   localparam int RD_LAT  = 2;
   localparam int RD_TIME = RD_LAT + 2;
   localparam int L       = 2 * RD_TIME + 6;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [15:0]   vid_data;
   logic          vid_valid;
   logic          cpu_stb = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [15:0]   cpu_din = '0;
   logic [1:0]    cpu_wtbt = '0;
   logic [15:0]   cpu_dout;
   logic          cpu_ack;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [1:0]    ram_be;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata;
   logic [1:0]    dbg_state;

   vram_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
      .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_wtbt(cpu_wtbt), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk_sys = ~clk_sys;
   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] init_word(input int a);
      if (a == 32'h0123) return 16'hA5C3;
      return 16'(a * 40503) ^ 16'h3C5A;
   endfunction

   // behavioural RAM with RD_LAT read latency
   logic          init_en = 1'b1;
   logic [15:0]   mem [0:(1<<AW)-1];
   logic [AW-1:0] apipe [0:RD_LAT-1];
   always @(posedge clk_sys) begin
      if (init_en) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      end else if (ram_we) begin
         if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
         if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      end
      apipe[0] <= ram_addr;
      for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign ram_rdata = mem[apipe[RD_LAT-1]];

   // reference memory image
   logic [15:0] ref_mem [0:(1<<AW)-1];
   task automatic apply_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
      if (be == 2'b00 || be[1]) ref_mem[a][15:8] = d[15:8];
      if (be == 2'b00 || be[0]) ref_mem[a][7:0]  = d[7:0];
   endtask

   // scoreboard / monitors
   logic [15:0]   exp_q[$];
   int            we_cnt = 0, vid_cnt = 0, ack_cnt = 0, vid_cyc = -1, ack_cyc = -1;
   logic [1:0]    we_be = '0;
   logic [AW-1:0] we_addr = '0;
   logic [15:0]   we_data = '0;
   logic          ack_d = 1'b0;
   always @(negedge clk_sys) begin
      if (ram_we) begin
         we_cnt  <= we_cnt + 1;
         we_be   <= ram_be;
         we_addr <= ram_addr;
         we_data <= ram_wdata;
      end
      if (vid_valid) begin
         vid_cnt <= vid_cnt + 1;
         vid_cyc <= cyc;
         if (exp_q.size() == 0) check("vid_unexpected", 32'd1, 32'd0);
         else check("vid_data", {16'h0, vid_data}, {16'h0, exp_q.pop_front()});
      end
      if (cpu_ack && !ack_d) begin
         ack_cnt <= ack_cnt + 1;
         ack_cyc <= cyc;
      end
      ack_d <= cpu_ack;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [15:0] din,
                         input logic [1:0] wtbt, input logic do_vid, input int k,
                         input logic [AW-1:0] va, input string tag);
      int s, w0, v0, a0, dur, vgrant;
      s = cyc; w0 = we_cnt; v0 = vid_cnt; a0 = ack_cnt;
      dur = we ? 2 : RD_TIME;
      cpu_stb = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_wtbt = wtbt;
      for (int step = 0; step < L; step++) begin
         vid_req  = do_vid && (step == k);
         vid_addr = va;
         if (do_vid && step == k) exp_q.push_back(ref_mem[va]);
         tick();
      end
      vid_req = 1'b0;
      check({tag, "_ack_cnt"}, ack_cnt - a0, 1);
      check({tag, "_ack_cyc"}, ack_cyc, s + dur + ((do_vid && k == 0) ? RD_TIME : 0));
      if (we) begin
         check({tag, "_we_cnt"}, we_cnt - w0, 1);
         check({tag, "_be"}, {30'h0, we_be}, (wtbt == 2'b00) ? 32'd3 : {30'h0, wtbt});
         check({tag, "_waddr"}, {18'h0, we_addr}, {18'h0, addr});
         check({tag, "_wdata"}, {16'h0, we_data}, {16'h0, din});
         apply_write(addr, din, wtbt);
      end else begin
         check({tag, "_no_we"}, we_cnt - w0, 0);
         check({tag, "_rdata"}, {16'h0, cpu_dout}, {16'h0, ref_mem[addr]});
      end
      if (do_vid) begin
         vgrant = (k == 0) ? s : ((s + k > s + dur) ? s + k : s + dur);
         check({tag, "_vid_cnt"}, vid_cnt - v0, 1);
         check({tag, "_vid_cyc"}, vid_cyc, vgrant + RD_TIME);
         check({tag, "_vid_bound"}, (vid_cyc - (s + k) <= 2 * RD_TIME) ? 1 : 0, 1);
      end
      cpu_stb = 1'b0;
      tick();
      check({tag, "_ack_fall"}, {31'h0, cpu_ack}, 0);
   endtask

   task automatic double_vid(input logic we, input logic [AW-1:0] addr, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input string tag);
      int s, v0, dur;
      s = cyc; v0 = vid_cnt;
      dur = we ? 2 : RD_TIME;
      cpu_stb = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = 16'h5678; cpu_wtbt = 2'b00;
      exp_q.push_back(ref_mem[a2]);
      for (int step = 0; step < L; step++) begin
         vid_req  = (step == 1) || (step == 2);
         vid_addr = (step == 1) ? a1 : a2;
         tick();
      end
      vid_req = 1'b0;
      if (we) apply_write(addr, 16'h5678, 2'b00);
      check({tag, "_one_fetch"}, vid_cnt - v0, 1);
      check({tag, "_vid_cyc"}, vid_cyc, s + dur + RD_TIME);
      cpu_stb = 1'b0;
      tick();
   endtask

   initial begin
      int s, a0, v0;
      logic [15:0] w200;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
      w200 = init_word(32'h0200);

      tick();
      init_en = 1'b0;
      tick(); tick();
      check("rst_vid_valid", {31'h0, vid_valid}, 0);
      check("rst_cpu_ack", {31'h0, cpu_ack}, 0);
      check("rst_ram_we", {31'h0, ram_we}, 0);
      check("rst_ram_be", {30'h0, ram_be}, 3);
      check("rst_vid_data", {16'h0, vid_data}, 0);
      check("rst_cpu_dout", {16'h0, cpu_dout}, 0);
      check("rst_ram_addr", {18'h0, ram_addr}, 0);
      check("rst_ram_wdata", {16'h0, ram_wdata}, 0);
      check("rst_state", {30'h0, dbg_state}, 0);
      reset = 1'b0;
      tick();

      // idle video fetch
      s = cyc; v0 = vid_cnt; a0 = we_cnt;
      vid_req = 1'b1; vid_addr = 14'h0123;
      exp_q.push_back(ref_mem[14'h0123]);
      tick();
      vid_req = 1'b0;
      check("vid_ram_addr", {18'h0, ram_addr}, 32'h0123);
      repeat (6) tick();
      check("vid_cnt", vid_cnt - v0, 1);
      check("vid_cyc", vid_cyc, s + 2 + RD_LAT);
      check("vid_held", {16'h0, vid_data}, 32'hA5C3);
      check("vid_no_we", we_cnt - a0, 0);

      // byte write and readback
      cpu_op(1'b1, 14'h0200, 16'h12AB, 2'b01, 1'b0, 0, '0, "bytewr");
      cpu_op(1'b0, 14'h0200, 16'h0000, 2'b00, 1'b0, 0, '0, "byterd");
      check("byte_lo", {24'h0, cpu_dout[7:0]}, 32'hAB);
      check("byte_hi", {24'h0, cpu_dout[15:8]}, {24'h0, w200[15:8]});

      // collision and video during CPU read
      cpu_op(1'b0, 14'h0123, 16'h0000, 2'b00, 1'b1, 0, 14'h3001, "collide");
      check("collide_dout", {16'h0, cpu_dout}, 32'hA5C3);
      cpu_op(1'b0, 14'h0300, 16'h0000, 2'b00, 1'b1, 1, 14'h3002, "vid_in_rd");

      // repeated video requests collapse to one fetch
      double_vid(1'b1, 14'h0400, 14'h0010, 14'h0020, "dbl_wr");
      double_vid(1'b0, 14'h0600, 14'h3003, 14'h3004, "dbl_rd");

      // reset in the write access cycle
      a0 = ack_cnt;
      cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0500; cpu_din = 16'hBEEF; cpu_wtbt = 2'b00;
      tick();
      check("rstwr_we_on", {31'h0, ram_we}, 1);
      reset = 1'b1;
      tick();
      check("rstwr_we", {31'h0, ram_we}, 0);
      check("rstwr_ack", {31'h0, cpu_ack}, 0);
      check("rstwr_vv", {31'h0, vid_valid}, 0);
      reset = 1'b0;
      apply_write(14'h0500, 16'hBEEF, 2'b00);
      repeat (8) tick();
      check("rstwr_reack", ack_cnt - a0, 1);
      cpu_stb = 1'b0;
      tick();
      cpu_op(1'b0, 14'h0500, 16'h0000, 2'b00, 1'b0, 0, '0, "rstwr_rd");

      // reset in the second read cycle, with a pending fetch dropped
      a0 = ack_cnt; v0 = vid_cnt;
      cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
      tick();
      vid_req = 1'b1; vid_addr = 14'h3005;
      tick();
      vid_req = 1'b0;
      reset = 1'b1;
      tick();
      s = cyc;
      check("rstrd_we", {31'h0, ram_we}, 0);
      check("rstrd_ack", {31'h0, cpu_ack}, 0);
      check("rstrd_vv", {31'h0, vid_valid}, 0);
      reset = 1'b0;
      repeat (10) tick();
      check("rstrd_reack", ack_cnt - a0, 1);
      check("rstrd_ack_cyc", ack_cyc, s + RD_TIME);
      check("rstrd_dout", {16'h0, cpu_dout}, 32'hA5C3);
      check("rstrd_no_vid", vid_cnt - v0, 0);
      cpu_stb = 1'b0;
      tick();

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         cpu_op(1'($urandom_range(0, 1)), 14'($urandom_range(0, 255)), 16'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                14'(14'h3000 + $urandom_range(0, 255)), "rnd");
      end

      repeat (4) tick();
      check("exp_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single-port 16-bit video RAM between the display fetch engine and the CPU bus. Video word fetches (one per 16 pixels) have strict priority; CPU reads and byte/word writes are serviced in the remaining slots with a stb/ack handshake. The block sits between the video controller's `vram_addr`/`vram_data` path, the CPU bus decoder, and the physical RAM.

## Interface
- `AW`, 14: word address width
- `RD_LAT`, 2: RAM read latency in clk_sys cycles (1..4)

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `vid_req`  in  1  one-cycle fetch request
- `vid_addr`  in  AW  fetch address, sampled with `vid_req`
- `vid_data`  out  16  last fetched word, held
- `vid_valid`  out  1  one-cycle pulse when `vid_data` updates
- `cpu_stb`  in  1  level request, held until `cpu_ack`
- `cpu_we`  in  1  1 = write
- `cpu_addr`  in  AW  word address
- `cpu_din`  in  16  write data
- `cpu_wtbt`  in  2  byte enables {hi,lo}; 2'b00 means a word write
- `cpu_dout`  out  16  read data, held
- `cpu_ack`  out  1  level; high until `cpu_stb` falls
- `ram_addr`  out  AW  registered
- `ram_we`  out  1  registered
- `ram_be`  out  2  registered; 2'b11 on reads
- `ram_wdata`  out  16  registered
- `ram_rdata`  in  16  valid `RD_LAT` cycles after address

## Operation
- FSM states: `IDLE`, `VID_RD`, `CPU_RD`, `CPU_WR`.
- `vid_pend` flag:
  - Set by `vid_req` in any state other than a same-cycle grant.
  - `vid_addr` is latched with it.
  - A `vid_req` while already pending replaces the latched address; only one fetch is performed.
- `IDLE` grant, evaluated on `vid_req | vid_pend`, then `cpu_stb & ~cpu_done`:
  - Video is always granted first → `VID_RD`.
  - Otherwise a CPU request is granted → `CPU_RD` or `CPU_WR`.
- Grant cycle G: RAM outputs are registered, so the access cycle is A = G+1.
- Read (`VID_RD` or `CPU_RD`):
  - A down-counter of `RD_LAT` runs from A.
  - `ram_rdata` is sampled at the end of cycle A+RD_LAT.
  - Result is visible at A+RD_LAT+1, then the FSM returns to `IDLE`.
- `CPU_WR`:
  - `ram_we` is high for cycle A only.
  - `ram_be` = `cpu_wtbt` (00→11).
  - Return to `IDLE` at A+1.
- `cpu_done`:
  - Set on CPU completion; it drives `cpu_ack`.
  - Cleared when `cpu_stb` is low.
  - Blocks a re-grant of the same CPU cycle.
- CPU abort:
  - If `cpu_stb` falls mid-access, the RAM access still completes (the write is performed).
  - `cpu_ack` is not raised, `cpu_done` is not set, and `cpu_dout` is still updated.
- Video waits at most one in-flight CPU access: worst-case fetch latency is (RD_LAT+2) + (RD_LAT+2) cycles.
- `ram_we` is 0 in every cycle except a write access cycle.

## Timing
- Reset values:
  - FSM = `IDLE`; `vid_pend`, `cpu_done`, `cpu_ack`, `vid_valid`, `ram_we` = 0.
  - `ram_be` = 2'b11; `vid_data`, `cpu_dout`, `ram_addr`, `ram_wdata` = 0.
- Reset mid-access:
  - Next edge forces `IDLE` and `ram_we` = 0.
  - Pending requests are dropped and the access is abandoned.
  - A CPU still asserting `cpu_stb` after reset is re-serviced from scratch.
- Idle video fetch: `vid_req` at cycle R → `ram_addr` at R+1 → `vid_valid` at R+2+RD_LAT (R+4 for RD_LAT=2).
- Idle CPU read: `cpu_stb` first high at S → `cpu_ack` and `cpu_dout` at S+2+RD_LAT.
- Idle CPU write: `cpu_stb` first high at S → `ram_we` at S+1 → `cpu_ack` at S+2.
- `vid_req` and `cpu_stb` both rising in the same idle cycle: video is granted, and CPU is granted in the cycle the FSM re-enters `IDLE`.
- Back-to-back: after returning to `IDLE` a new grant occurs the same cycle. There is no dead cycle between accesses.
- `cpu_ack` falls one cycle after `cpu_stb` falls.

## Test plan
- Idle video fetch, RAM[0x0123] = 16'hA5C3, `vid_req` at cycle 10 → `ram_addr` = 0x0123 at cycle 11, `vid_valid` pulse with `vid_data` = 16'hA5C3 at cycle 14, `ram_we` never high.
- CPU byte write:
  - Stimulus: `cpu_we` = 1, addr 0x0200, `cpu_din` = 16'h12AB, `cpu_wtbt` = 2'b01.
  - Response: one `ram_we` cycle with `ram_be` = 2'b01, `cpu_ack` two cycles after `cpu_stb`.
  - Readback of 0x0200 gives hi byte unchanged, lo byte = 8'hAB.
- Collision: `cpu_stb` read and `vid_req` in the same cycle → video access first, `vid_valid` at +4, CPU `ram_addr` presented the following cycle, `cpu_ack` at +8.
- Video during CPU read: `vid_req` one cycle after a CPU grant → video waits, fetched immediately after CPU completion, `vid_valid` ≤ 8 cycles after `vid_req`.
- Double `vid_req` (addr 0x10 then 0x20) while a CPU write is in flight → exactly one fetch, from 0x20.
- Reset asserted in the `ram_we` cycle of a write and in the second cycle of a read → next cycle `ram_we` = 0, `cpu_ack` = 0, `vid_valid` = 0. After release, a still-held `cpu_stb` completes normally.
